// File: rtl/max7219_cmd_scheduler.sv
// rtl/max7219_cmd_scheduler.sv - MAX7219 init/refresh/host command scheduler onto one serializer link.
// Optional last-sent digit suppression is built when MAX7219_DIRTY_EN is defined.
module max7219_cmd_scheduler #(
    parameter int         NUM_DIGITS      = 8,
    parameter logic [7:0] SCAN_LIMIT_INIT = 8'd7,
    parameter logic [3:0] INTENSITY_INIT  = 4'hF,
    parameter int         REFRESH_DIV     = 50000
) (
    input  logic        clk,
    input  logic        reset_sw,
    input  logic [31:0] frame,
    input  logic        host_req,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        host_gnt,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        cmd_ready,
    output logic        init_done,
    output logic        busy
);

    localparam int            TW         = $clog2(REFRESH_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SWEEP, S_HOST} state_t;

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [2:0]    digit_q, digit_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          pending_q, pending_d;
    logic [31:0]   snap_q, snap_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_addr_q, cmd_addr_d;
    logic [7:0]    cmd_data_q, cmd_data_d;
    logic          gap_q, gap_d;
    logic          init_done_q, init_done_d;
    logic          host_ok_q, host_ok_d;
    logic          ret_sweep_q, ret_sweep_d;
`ifdef MAX7219_DIRTY_EN
    logic [31:0]   last_q, last_d;
    logic [7:0]    lvalid_q, lvalid_d;
    logic          digit_clean;
`endif

    logic       xfer, slot_free, tick, in_sweep, start_sweep;
    logic [3:0] nib;
    logic [7:0] init_addr, init_data;

    assign xfer      = cmd_valid_q & cmd_ready;
    assign slot_free = ~cmd_valid_q & ~gap_q;
    assign tick      = init_done_q & (tick_q == TICK_LAST);
    assign in_sweep  = (state_q == S_SWEEP) | ((state_q == S_HOST) & ret_sweep_q);
    assign nib       = snap_q[{digit_q, 2'b00} +: 4];
`ifdef MAX7219_DIRTY_EN
    assign digit_clean = lvalid_q[digit_q] & (last_q[{digit_q, 2'b00} +: 4] == nib);
`endif

    always_comb begin
        init_addr = 8'h09;
        init_data = 8'h00;
        case (step_q)
            3'd0:    begin init_addr = 8'h0F; init_data = 8'h00; end
            3'd1:    begin init_addr = 8'h0C; init_data = 8'h01; end
            3'd2:    begin init_addr = 8'h0B; init_data = SCAN_LIMIT_INIT; end
            3'd3:    begin init_addr = 8'h0A; init_data = {4'h0, INTENSITY_INIT}; end
            default: begin init_addr = 8'h09; init_data = 8'h00; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        digit_d     = digit_q;
        pending_d   = pending_q;
        snap_d      = snap_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        gap_d       = 1'b0;
        init_done_d = init_done_q;
        host_ok_d   = host_ok_q;
        ret_sweep_d = ret_sweep_q;
        start_sweep = 1'b0;
        tick_d      = tick_q;
`ifdef MAX7219_DIRTY_EN
        last_d      = last_q;
        lvalid_d    = lvalid_q;
`endif
        if (init_done_q) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_INIT: begin
                if (slot_free) begin
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = init_addr;
                    cmd_data_d  = init_data;
                end
                if (xfer) begin
                    cmd_valid_d = 1'b0;
                    gap_d       = 1'b1;
                    if (step_q == 3'd4) begin
                        init_done_d = 1'b1;
                        pending_d   = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                if (slot_free) begin
                    if (host_req) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = host_addr;
                        cmd_data_d  = host_data;
                        ret_sweep_d = 1'b0;
                        state_d     = S_HOST;
                    end else if (pending_q) begin
                        start_sweep = 1'b1;
                        pending_d   = 1'b0;
                        snap_d      = frame;
                        digit_d     = 3'd0;
                        host_ok_d   = 1'b1;
                        state_d     = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                // host_ok_q alternates host and digit slots so the sweep always makes progress
                if (slot_free) begin
                    if (host_req && host_ok_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = host_addr;
                        cmd_data_d  = host_data;
                        ret_sweep_d = 1'b1;
                        host_ok_d   = 1'b0;
                        state_d     = S_HOST;
                    end
`ifdef MAX7219_DIRTY_EN
                    else if (digit_clean) begin
                        if (digit_q == DIGIT_LAST) begin
                            state_d = S_IDLE;
                        end else begin
                            digit_d = digit_q + 3'd1;
                        end
                    end
`endif
                    else begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = {5'd0, digit_q} + 8'd1;
                        cmd_data_d  = {4'h0, nib};
                    end
                end
                if (xfer) begin
                    cmd_valid_d = 1'b0;
                    gap_d       = 1'b1;
                    host_ok_d   = 1'b1;
`ifdef MAX7219_DIRTY_EN
                    last_d[{digit_q, 2'b00} +: 4] = cmd_data_q[3:0];
                    lvalid_d[digit_q]             = 1'b1;
`endif
                    if (digit_q == DIGIT_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        digit_d = digit_q + 3'd1;
                    end
                end
            end
            S_HOST: begin
                if (xfer) begin
                    cmd_valid_d = 1'b0;
                    gap_d       = 1'b1;
                    host_ok_d   = 1'b0;
                    state_d     = ret_sweep_q ? S_SWEEP : S_IDLE;
`ifdef MAX7219_DIRTY_EN
                    if (cmd_addr_q >= 8'd1 && cmd_addr_q <= 8'd8) begin
                        lvalid_d[3'(cmd_addr_q - 8'd1)] = 1'b0;
                    end
`endif
                end
            end
            default: state_d = S_INIT;
        endcase

        // A tick landing in an active or just-starting sweep is absorbed, not queued
        if (tick && !in_sweep && !start_sweep) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sw) begin
            state_q     <= S_INIT;
            step_q      <= 3'd0;
            digit_q     <= 3'd0;
            tick_q      <= '0;
            pending_q   <= 1'b0;
            snap_q      <= 32'd0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= 8'd0;
            cmd_data_q  <= 8'd0;
            gap_q       <= 1'b0;
            init_done_q <= 1'b0;
            host_ok_q   <= 1'b0;
            ret_sweep_q <= 1'b0;
`ifdef MAX7219_DIRTY_EN
            last_q      <= 32'd0;
            lvalid_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            digit_q     <= digit_d;
            tick_q      <= tick_d;
            pending_q   <= pending_d;
            snap_q      <= snap_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            gap_q       <= gap_d;
            init_done_q <= init_done_d;
            host_ok_q   <= host_ok_d;
            ret_sweep_q <= ret_sweep_d;
`ifdef MAX7219_DIRTY_EN
            last_q      <= last_d;
            lvalid_q    <= lvalid_d;
`endif
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign init_done = init_done_q;
    assign host_gnt  = (state_q == S_HOST) & xfer;
    assign busy      = (state_q != S_IDLE);

endmodule
